// File: rtl/frame_buf.sv
// Frame buffer: writes N=2^AW samples into an external single-port RAM, then drains them (bit-reversed order when FRAME_BUF_BITREV_EN is defined, natural order otherwise).
// Latency: the first output is valid 2 cycles after the last input handshake; the drain then runs at one sample per clock.
// Backpressure: s_ready is low for the whole drain; m_ready=0 parks the RAM (mem_cs=0) so that m_data holds.
module frame_buf #(
   parameter int DW = 16,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic [DW-1:0] mem_data,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic          mem_cs,
   input  logic [DW-1:0] mem_q
);

   localparam logic [0:0]    FILL     = 1'b0;
   localparam logic [0:0]    DRAIN    = 1'b1;
   localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
   localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};

   logic [0:0]    state;
   logic [AW-1:0] wr_cnt;
   logic [AW-1:0] rd_cnt;
   logic          rd_all;
   logic          wr_fire;
   logic          rd_fire;

   function automatic logic [AW-1:0] rd_order(input logic [AW-1:0] idx);
`ifdef FRAME_BUF_BITREV_EN
      logic [AW-1:0] rev;
      rev = '0;
      for (int b = 0; b < AW; b++) rev[b] = idx[AW-1-b];
      return rev;
`else
      return idx;
`endif
   endfunction

   // Outputs are gated by rst_n so that the RAM is not strobed while reset is held.
   assign s_ready  = rst_n & (state == FILL);
   assign wr_fire  = s_ready & s_valid;
   // A read is issued when the output slot is empty or is being emptied in this cycle.
   assign rd_fire  = rst_n & (state == DRAIN) & ~rd_all & (~m_valid | m_ready);
   assign mem_cs   = wr_fire | rd_fire;
   assign mem_we   = wr_fire;
   assign mem_data = wr_fire ? s_data : '0;
   assign mem_addr = (state == FILL) ? wr_cnt : rd_order(rd_cnt);
   assign m_data   = mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FILL;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         rd_all  <= 1'b0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (wr_fire) begin
                  wr_cnt <= wr_cnt + ONE;
                  if (wr_cnt == LAST_IDX) state <= DRAIN;
               end
            end
            default: begin
               if (rd_fire) begin
                  rd_cnt  <= rd_cnt + ONE;
                  m_valid <= 1'b1;
                  m_last  <= (rd_cnt == LAST_IDX);
                  if (rd_cnt == LAST_IDX) rd_all <= 1'b1;
               end else if (m_valid && m_ready) begin
                  m_valid <= 1'b0;
                  m_last  <= 1'b0;
                  if (m_last) begin
                     state  <= FILL;
                     rd_all <= 1'b0;
                     rd_cnt <= '0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_buf.sv
// Directed bench for frame_buf with AW=3, driving a behavioural single-port RAM.
module tb_frame_buf;

   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic [DW-1:0] mem_data;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic          mem_cs;
   logic [DW-1:0] mem_q;

   logic [DW-1:0] ram [8];
   logic [AW-1:0] ram_ra;

   int n_cmp;
   int n_bad;
   int ord [8];

   frame_buf #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .mem_data(mem_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_cs(mem_cs),
      .mem_q(mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we) ram[mem_addr] <= mem_data;
         ram_ra <= mem_addr;
      end
   end
   assign mem_q = ram[ram_ra];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Each cycle: enter just after a rising edge, drive at +1, sample at +2.
   task automatic send_frame(input int base, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         #1 s_valid = 1'b1; s_data = DW'(base + i); m_ready = 1'b1;
         #1;
         check("wr_rdy",  32'(s_ready), 32'd1);
         check("wr_we",   32'(mem_we), 32'd1);
         check("wr_addr", 32'(mem_addr), 32'(i));
         check("wr_data", 32'(mem_data), 32'(base + i));
         check("wr_mvld", 32'(m_valid), 32'd0);
         @(posedge clk);
         if (gaps && i < 7) begin
            for (int g = 0; g < 2; g++) begin
               #1 s_valid = 1'b0;
               #1;
               check("gap_cs", 32'(mem_cs), 32'd0);
               check("gap_we", 32'(mem_we), 32'd0);
               @(posedge clk);
            end
         end
      end
   endtask

   task automatic drain(input int base, input int n_out, input bit stall, input bit hold_sv);
      #1 m_ready = 1'b1; s_valid = hold_sv; s_data = 16'd99;
      #1;
      check("iss_mvld", 32'(m_valid), 32'd0);
      check("iss_cs",   32'(mem_cs), 32'd1);
      check("iss_addr", 32'(mem_addr), 32'(ord[0]));
      check("iss_rdy",  32'(s_ready), 32'd0);
      @(posedge clk);
      for (int k = 0; k < n_out; k++) begin
         if (stall && k == 2) begin
            for (int s = 0; s < 5; s++) begin
               #1 m_ready = 1'b0;
               #1;
               check("stl_vld",  32'(m_valid), 32'd1);
               check("stl_data", 32'(m_data), 32'(base + ord[k]));
               check("stl_cs",   32'(mem_cs), 32'd0);
               @(posedge clk);
            end
         end
         #1 m_ready = 1'b1;
         #1;
         check("out_vld",  32'(m_valid), 32'd1);
         check("out_data", 32'(m_data), 32'(base + ord[k]));
         check("out_last", 32'(m_last), (k == 7) ? 32'd1 : 32'd0);
         check("nxt_cs",   32'(mem_cs), (k < 7) ? 32'd1 : 32'd0);
         if (k < 7) check("nxt_addr", 32'(mem_addr), 32'(ord[k+1]));
         if (hold_sv) begin
            check("hold_rdy", 32'(s_ready), 32'd0);
            check("hold_we",  32'(mem_we), 32'd0);
         end
         @(posedge clk);
      end
   endtask

   task automatic idle_check();
      #1 s_valid = 1'b0;
      #1;
      check("post_rdy",  32'(s_ready), 32'd1);
      check("post_mvld", 32'(m_valid), 32'd0);
      @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
`ifdef FRAME_BUF_BITREV_EN
      ord = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
      ord = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 16'hABCD;
      m_ready = 1'b1;
      #3;
      check("rst_mvld",  32'(m_valid), 32'd0);
      check("rst_mlast", 32'(m_last), 32'd0);
      check("rst_cs",    32'(mem_cs), 32'd0);
      check("rst_we",    32'(mem_we), 32'd0);
      check("rst_addr",  32'(mem_addr), 32'd0);
      check("rst_data",  32'(mem_data), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1; s_valid = 1'b0;
      #1;
      check("rel_rdy", 32'(s_ready), 32'd1);
      @(posedge clk);

      // Back-to-back frame, full-rate drain.
      send_frame(0, 1'b0);
      drain(0, 8, 1'b0, 1'b0);
      idle_check();

      // Output stall on the third sample.
      send_frame(32'h20, 1'b0);
      drain(32'h20, 8, 1'b1, 1'b0);
      idle_check();

      // Input gaps during fill.
      send_frame(32'h30, 1'b1);
      drain(32'h30, 8, 1'b0, 1'b0);
      idle_check();

      // Reset in the middle of the drain, then a fresh frame.
      send_frame(32'h40, 1'b0);
      drain(32'h40, 4, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_mvld",  32'(m_valid), 32'd0);
      check("mid_mlast", 32'(m_last), 32'd0);
      check("mid_cs",    32'(mem_cs), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      send_frame(10, 1'b0);
      drain(10, 8, 1'b0, 1'b0);
      idle_check();

      // s_valid held high through the drain; next frame starts cleanly.
      send_frame(32'h50, 1'b0);
      drain(32'h50, 8, 1'b0, 1'b1);
      send_frame(32'h60, 1'b0);
      drain(32'h60, 8, 1'b0, 1'b0);
      idle_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_buf.md
FRAME_BUF -- requirements
Module: frame_buf

Interface
REQ-001 SHALL have parameter DW, default 16, meaning sample data width in bits.
REQ-002 SHALL have parameter AW, default 10, meaning frame address width; frame length N = 2^AW samples.
REQ-003 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset.
REQ-004 SHALL have ports: s_data input DW, input sample; s_valid input 1, input sample valid; s_ready output 1, block accepts input.
REQ-005 SHALL have ports: m_data output DW, output sample; m_valid output 1, output valid; m_ready input 1, downstream accepts; m_last output 1, final sample of frame.
REQ-006 SHALL have ports: mem_data output DW, write data; mem_addr output AW, RAM address; mem_we output 1, write enable; mem_cs output 1, chip select; mem_q input DW, RAM read data.
REQ-007 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-008 SHALL drive an external single-port RAM port: address registered on clk when mem_cs=1; write on clk when mem_cs=1 and mem_we=1; mem_q = word at last registered address, stable while mem_cs=0.
REQ-009 SHALL implement FSM states FILL, DRAIN, with reset state FILL.
REQ-010 In FILL: s_ready=1, m_valid=0; each s_valid&s_ready cycle drives mem_cs=1, mem_we=1, mem_addr=wr_cnt, mem_data=s_data, and increments wr_cnt.
REQ-011 FILL with s_valid=0 SHALL drive mem_cs=0, with wr_cnt held.
REQ-012 The handshake with wr_cnt=N-1 SHALL wrap wr_cnt to 0 and move to DRAIN on the next cycle.
REQ-013 In DRAIN: s_ready=0, mem_we=0; read address = rd_order(rd_cnt).
REQ-014 The first DRAIN cycle SHALL issue a read (mem_cs=1) of rd_cnt=0 and increment rd_cnt.
REQ-015 m_valid SHALL go to 1 the cycle after a read issue, with m_data=mem_q combinationally.
REQ-016 While m_valid=1 and m_ready=0, mem_cs SHALL be 0, so mem_q and m_data hold.
REQ-017 On m_valid&m_ready with reads remaining, the next read SHALL be issued in the same cycle, giving one sample per clock at full throughput.
REQ-018 Read latency SHALL be 1 cycle from read issue to m_valid.
REQ-019 m_last SHALL be 1 while m_valid=1 and the presented sample is the N-th of the frame.
REQ-020 On the m_last handshake: m_valid->0, rd_cnt->0, FSM->FILL next cycle; s_ready may rise that next cycle.
REQ-021 Counters SHALL be AW bits and wrap modulo N; no other arithmetic.
REQ-022 An s_valid in DRAIN SHALL be ignored (s_ready=0) and no input data lost; an m_ready in FILL SHALL be ignored.

Reset
REQ-023 rst_n=0 SHALL asynchronously set FSM=FILL, wr_cnt=0, rd_cnt=0, m_valid=0, m_last=0, mem_cs=0, mem_we=0, mem_addr=0, mem_data=0; s_ready=1 after release.
REQ-024 Reset mid-frame SHALL discard the partial frame with no further output; RAM contents are not cleared.

Configuration
REQ-025 With macro FRAME_BUF_BITREV_EN defined, rd_order(i) SHALL be i with its AW bits reversed (FFT bit-reversal reorder).
REQ-026 Without FRAME_BUF_BITREV_EN, rd_order(i)=i and the block SHALL act as a natural-order frame FIFO; all timing is identical in both builds.

Verification
REQ-027 AW=3, bitrev, inputs 0..7 back-to-back, m_ready=1 -> outputs 0,4,2,6,1,5,3,7 on 8 consecutive cycles, m_last on 7, s_ready=1 the next cycle.
REQ-028 Same, macro undefined -> outputs 0..7 in order, first m_valid exactly 2 cycles after the last input handshake.
REQ-029 m_ready held 0 for 5 cycles on the 3rd output -> m_data stable, mem_cs=0 throughout, no sample duplicated or skipped.
REQ-030 s_valid gaps during FILL (pattern 1,0,0,1...) -> mem_we only on handshakes, wr_cnt contiguous, output correct.
REQ-031 rst_n pulsed low after 4 of 8 drain outputs -> m_valid=0 immediately; new frame 10..17 drains correctly from index 0.
REQ-032 s_valid=1 held throughout DRAIN -> s_ready=0, no writes; the next frame starts with the sample presented after return to FILL.
